// File: rtl/map_pkg.sv
// Shared definitions for the map stage and its list_fold back end.
//   element_t    : (value, pointer) pair used for list cells in map.
//   fold_op_e    : fold operator selector sampled with the head pointer.
//   fold_state_e : list_fold controller states.
//   NIL_IDX      : index of the Nil sentinel cell.
package map_pkg;

    localparam int ELEM_DATA_W = 32;
    localparam int ELEM_PTR_W  = 8;
    localparam int NIL_IDX     = 0;

    typedef struct packed {
        logic [ELEM_DATA_W-1:0] value;
        logic [ELEM_PTR_W-1:0]  ptr;
    } element_t;

    typedef enum logic [1:0] {
        FOLD_SUM   = 2'b00,
        FOLD_MAX   = 2'b01,
        FOLD_COUNT = 2'b10,
        FOLD_XOR   = 2'b11
    } fold_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WALK = 2'b01,
        ST_DONE = 2'b10
    } fold_state_e;

endpackage

// File: rtl/list_fold_mem.sv
// Cell buffer for list_fold: DEPTH x DATA_W register file with one
// synchronous write port and one combinational read port.
//   clk     : clock
//   wr_en   : write strobe
//   wr_idx  : write index
//   wr_data : write value
//   rd_idx  : read index
//   rd_data : read value (combinational from rd_idx)
module list_fold_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are deliberately not reset; every cell is written before use.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/list_fold.sv
// list_fold: buffers result-list cells written by map, then on receipt of
// the final list pointer walks cells head_ptr-1 down to 1 and reduces them
// with the selected operator. The result leaves on a ready/valid channel.
//   clk, rst                           : clock, synchronous active-high reset
//   cell_valid/cell_ready/idx/data     : cell write channel (IDLE only)
//   head_valid/head_ready/head_ptr/op  : list length (incl. Nil) + operator
//   res_valid/res_ready                : result handshake
//   res_data, res_len, res_err         : folded value, cells folded, bad head
module list_fold
    import map_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cell_valid,
    output logic              cell_ready,
    input  logic [PTR_W-1:0]  cell_idx,
    input  logic [DATA_W-1:0] cell_data,
    input  logic              head_valid,
    output logic              head_ready,
    input  logic [PTR_W:0]    head_ptr,
    input  logic [1:0]        op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [PTR_W:0]    res_len,
    output logic              res_err
);

    localparam logic [PTR_W:0]   HEAD_MAX  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NIL_IDX + 1);

    fold_state_e       state_q, state_d;
    fold_op_e          op_q, op_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [PTR_W:0]    len_q, len_d;
    logic [PTR_W-1:0]  p_q, p_d;
    logic              err_q, err_d;

    logic              cell_wr;
    logic [DATA_W-1:0] rd_data;

    function automatic logic [DATA_W-1:0] fold_step(
        input fold_op_e          f,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] x
    );
        logic [DATA_W-1:0] r;
        case (f)
            FOLD_SUM:   r = a + x;
            FOLD_MAX:   r = (x > a) ? x : a;
            FOLD_COUNT: r = a + DATA_W'(1);
            FOLD_XOR:   r = a ^ x;
            default:    r = a;
        endcase
        return r;
    endfunction

    list_fold_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (cell_wr),
        .wr_idx  (cell_idx),
        .wr_data (cell_data),
        .rd_idx  (p_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        len_d   = len_q;
        p_d     = p_q;
        err_d   = err_q;
        cell_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A cell written on the same edge as the head is accepted is
                // already in the buffer when the walk reads it next cycle.
                cell_wr = cell_valid;
                if (head_valid) begin
                    op_d  = fold_op_e'(op);
                    acc_d = '0;
                    len_d = '0;
                    if (head_ptr == '0 || head_ptr > HEAD_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (head_ptr == (PTR_W + 1)'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        p_d     = PTR_W'(head_ptr - (PTR_W + 1)'(1));
                        state_d = ST_WALK;
                    end
                end
            end
            ST_WALK: begin
                acc_d = fold_step(op_q, acc_q, rd_data);
                len_d = len_q + (PTR_W + 1)'(1);
                if (p_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    p_d = p_q - PTR_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= FOLD_SUM;
            acc_q   <= '0;
            len_q   <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end

    // All handshake outputs decode the state register only, so res_ready
    // has no combinational route to cell_ready or head_ready.
    assign cell_ready = (state_q == ST_IDLE);
    assign head_ready = (state_q == ST_IDLE);
    assign res_valid  = (state_q == ST_DONE);
    assign res_data   = acc_q;
    assign res_len    = len_q;
    assign res_err    = err_q;

endmodule

// File: tb/tb_list_fold.sv
module tb_list_fold;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cell_valid = 1'b0;
    logic        cell_ready;
    logic [2:0]  cell_idx = '0;
    logic [31:0] cell_data = '0;
    logic        head_valid = 1'b0;
    logic        head_ready;
    logic [3:0]  head_ptr = '0;
    logic [1:0]  op = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_len;
    logic        res_err;

    int checks = 0;
    int passes = 0;

    logic [31:0] model_mem [8];

    always #5 clk = ~clk;

    list_fold #(.DEPTH(8), .DATA_W(32), .PTR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_idx   (cell_idx),
        .cell_data  (cell_data),
        .head_valid (head_valid),
        .head_ready (head_ready),
        .head_ptr   (head_ptr),
        .op         (op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_len    (res_len),
        .res_err    (res_err)
    );

    // Reference: fold the list from the last cell down to 1 using plain
    // arithmetic on the bench's own copy of the cell contents.
    function automatic void ref_fold(input int ptr, input int opv,
                                     output logic [31:0] d, output int l,
                                     output logic e, output int lat);
        d = 0; l = 0; e = 0; lat = 1;
        if (ptr < 1 || ptr > 8) begin
            e = 1;
        end else begin
            if (ptr > 1) lat = ptr - 1;
            for (int i = ptr - 1; i >= 1; i--) begin
                case (opv)
                    0: d = d + model_mem[i];
                    1: if (model_mem[i] > d) d = model_mem[i];
                    2: d = d + 1;
                    default: d = d ^ model_mem[i];
                endcase
                l++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int idx, input logic [31:0] d);
        int n = 0;
        while (cell_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        cell_valid = 1'b1;
        cell_idx   = idx[2:0];
        cell_data  = d;
        tick();
        cell_valid = 1'b0;
        model_mem[idx] = d;
    endtask

    // Offers a head (optionally with a cell in the same cycle), measures the
    // cycles to res_valid, captures the outputs and accepts the result.
    task automatic run_fold(input int ptr, input int opv, input bit with_cell,
                            input int cidx, input logic [31:0] cdat,
                            output int lat, output logic [31:0] d,
                            output logic [3:0] l, output logic e);
        head_valid = 1'b1;
        head_ptr   = ptr[3:0];
        op         = opv[1:0];
        if (with_cell) begin
            cell_valid = 1'b1;
            cell_idx   = cidx[2:0];
            cell_data  = cdat;
            model_mem[cidx] = cdat;
        end
        tick();
        head_valid = 1'b0;
        cell_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (res_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        d = res_data;
        l = res_len;
        e = res_err;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cell_ready, head_ready, res_valid, res_err} !== 4'b1100 ||
            res_data !== 32'd0 || res_len !== 4'd0)
            $display("FAIL reset_state: rdy=%b%b vld=%b err=%b data=%h len=%0d, want rdy=11 vld=0 err=0 data=0 len=0",
                     cell_ready, head_ready, res_valid, res_err, res_data, res_len);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ops();
        int lat, elat, el;
        logic [31:0] d, ed;
        logic [3:0] l;
        logic e, ee;
        write_cell(0, 32'hDEAD_BEEF);
        for (int i = 1; i <= 5; i++) write_cell(i, i + 1);
        write_cell(6, 32'h1234_5678);
        write_cell(7, 32'hCAFE_0000);
        for (int o = 0; o < 4; o++) begin
            run_fold(6, o, 1'b0, 0, 0, lat, d, l, e);
            ref_fold(6, o, ed, el, ee, elat);
            checks++;
            if (lat !== elat || d !== ed || l !== 4'(el) || e !== ee)
                $display("FAIL op%0d_fold: lat=%0d data=%h len=%0d err=%b, want lat=%0d data=%h len=%0d err=%b",
                         o, lat, d, l, e, elat, ed, el, ee);
            else passes++;
            checks++;
            if (res_valid !== 1'b0 || head_ready !== 1'b1 || cell_ready !== 1'b1)
                $display("FAIL op%0d_release: vld=%b hrdy=%b crdy=%b, want 0 1 1",
                         o, res_valid, head_ready, cell_ready);
            else passes++;
        end
    endtask

    task automatic test_short_illegal();
        int ptrs [3] = '{1, 0, 9};
        int lat, elat, el;
        logic [31:0] d, ed;
        logic [3:0] l;
        logic e, ee;
        foreach (ptrs[j]) begin
            run_fold(ptrs[j], 0, 1'b0, 0, 0, lat, d, l, e);
            ref_fold(ptrs[j], 0, ed, el, ee, elat);
            checks++;
            if (lat !== elat || d !== ed || l !== 4'(el) || e !== ee)
                $display("FAIL head%0d: lat=%0d data=%h len=%0d err=%b, want lat=%0d data=%h len=%0d err=%b",
                         ptrs[j], lat, d, l, e, elat, ed, el, ee);
            else passes++;
            checks++;
            if (res_err !== 1'b0)
                $display("FAIL head%0d_errclr: err=%b, want 0", ptrs[j], res_err);
            else passes++;
        end
    endtask

    task automatic test_wrap_backpressure();
        int lat, elat, el;
        logic [31:0] d, ed;
        logic [3:0] l;
        logic e, ee;
        for (int i = 1; i <= 3; i++) write_cell(i, 32'hFFFF_FFFF);
        ref_fold(4, 0, ed, el, ee, elat);
        head_valid = 1'b1; head_ptr = 4'd4; op = 2'b00;
        tick();
        head_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (res_valid === 1'b1) begin lat = k; break; end
        end
        checks++;
        if (lat !== elat || res_data !== ed || res_len !== 4'(el) || res_err !== ee)
            $display("FAIL wrap_sum: lat=%0d data=%h len=%0d err=%b, want lat=%0d data=%h len=%0d err=%b",
                     lat, res_data, res_len, res_err, elat, ed, el, ee);
        else passes++;
        d = res_data; l = res_len; e = res_err;
        cell_valid = 1'b1; cell_idx = 3'd1; cell_data = 32'h11;
        for (int h = 0; h < 3; h++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== ed || res_len !== 4'(el) ||
                res_err !== ee || cell_ready !== 1'b0)
                $display("FAIL hold%0d: vld=%b data=%h len=%0d err=%b crdy=%b, want 1 %h %0d %b 0",
                         h, res_valid, res_data, res_len, res_err, cell_ready, ed, el, ee);
            else passes++;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || cell_ready !== 1'b1)
            $display("FAIL hold_release: vld=%b crdy=%b, want 0 1", res_valid, cell_ready);
        else passes++;
        tick();
        cell_valid = 1'b0;
        model_mem[1] = 32'h11;
        run_fold(2, 0, 1'b0, 0, 0, lat, d, l, e);
        ref_fold(2, 0, ed, el, ee, elat);
        checks++;
        if (lat !== elat || d !== ed || l !== 4'(el) || e !== ee)
            $display("FAIL late_cell: lat=%0d data=%h len=%0d err=%b, want lat=%0d data=%h len=%0d err=%b",
                     lat, d, l, e, elat, ed, el, ee);
        else passes++;
    endtask

    task automatic test_reset_mid_walk();
        int lat, elat, el;
        bit seen = 0;
        logic [31:0] d, ed;
        logic [3:0] l;
        logic e, ee;
        for (int i = 1; i <= 5; i++) write_cell(i, 32'h100 * i);
        head_valid = 1'b1; head_ptr = 4'd6; op = 2'b00;
        tick();
        head_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cell_ready !== 1'b1 || head_ready !== 1'b1 || res_valid !== 1'b0 || res_len !== 4'd0)
            $display("FAIL abort_state: crdy=%b hrdy=%b vld=%b len=%0d, want 1 1 0 0",
                     cell_ready, head_ready, res_valid, res_len);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            if (res_valid === 1'b1) seen = 1;
            tick();
        end
        checks++;
        if (seen) $display("FAIL abort_no_result: res_valid seen=1, want 0");
        else passes++;
        write_cell(1, 32'd7);
        write_cell(2, 32'd8);
        run_fold(3, 0, 1'b0, 0, 0, lat, d, l, e);
        ref_fold(3, 0, ed, el, ee, elat);
        checks++;
        if (lat !== elat || d !== ed || l !== 4'(el) || e !== ee)
            $display("FAIL after_abort: lat=%0d data=%h len=%0d err=%b, want lat=%0d data=%h len=%0d err=%b",
                     lat, d, l, e, elat, ed, el, ee);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lat, elat, el, ptr, opv, cidx;
        bit wc;
        logic [31:0] d, ed;
        logic [3:0] l;
        logic e, ee;
        for (int it = 0; it < 24; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                write_cell($urandom_range(0, 7), $urandom);
            ptr  = $urandom_range(0, 10);
            opv  = $urandom_range(0, 3);
            wc   = (it % 2 == 0) && ptr >= 2 && ptr <= 8;
            cidx = (ptr >= 2) ? int'($urandom_range(1, ptr - 1)) : 0;
            run_fold(ptr, opv, wc, cidx, $urandom, lat, d, l, e);
            ref_fold(ptr, opv, ed, el, ee, elat);
            checks++;
            if (lat !== elat || d !== ed || l !== 4'(el) || e !== ee)
                $display("FAIL rand%0d p=%0d op=%0d wc=%0d: lat=%0d data=%h len=%0d err=%b, want lat=%0d data=%h len=%0d err=%b",
                         it, ptr, opv, wc, lat, d, l, e, elat, ed, el, ee);
            else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model_mem[i] = 32'd0;
        test_reset();
        test_ops();
        test_short_illegal();
        test_wrap_backpressure();
        test_reset_mid_walk();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/list_fold.md
# list_fold

Downstream consumer of the map stage. Captures the result-list cells that map writes (value plus index, index 0 being the Nil sentinel), then, when map presents its final list pointer, walks the list from the last cell down to index 1 and reduces it to a single scalar with a selectable fold operator. The reduced value is returned over a ready/valid result channel. This gives the map pipeline a fold/reduce back end in the same ready/valid style as the rest of the datapath.

## Interface

Parameters:
- DEPTH, 8: number of list cells buffered, including the Nil cell at index 0.
- DATA_W, 32: width of a cell value and of the result.
- PTR_W, $clog2(DEPTH): width of a cell index.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cell_valid  in  1  a list-cell write is offered.
- cell_ready  out  1  a cell write can be accepted; high only in IDLE.
- cell_idx  in  PTR_W  cell index; 0 is Nil.
- cell_data  in  DATA_W  cell value.
- head_valid  in  1  the final list pointer from map is offered.
- head_ready  out  1  the head pointer can be accepted; high only in IDLE.
- head_ptr  in  PTR_W+1  list length including Nil (map's final_result).
- op  in  2  fold operator, sampled with the head pointer: 00 sum, 01 unsigned max, 10 count, 11 xor.
- res_valid  out  1  a result is presented.
- res_ready  in  1  the consumer accepts the result.
- res_data  out  DATA_W  the folded value.
- res_len  out  PTR_W+1  number of non-Nil cells folded.
- res_err  out  1  the head pointer was illegal (0 or greater than DEPTH).

## Operation

- FSM states: IDLE, WALK, DONE.
- IDLE:
  - A cell transfer (cell_valid && cell_ready) writes cell_data to mem[cell_idx]. An index-0 write is stored but never folded.
  - A head transfer latches head_ptr and op, and initialises acc=0 and len=0.
  - If head_ptr is 0 or greater than DEPTH: go to DONE with res_err=1, res_data=0, res_len=0.
  - If head_ptr is 1 (Nil only): go to DONE with acc=0.
  - Otherwise: set walk pointer p=head_ptr-1 and go to WALK.
- WALK: each cycle, read x=mem[p] combinationally and update acc:
  - sum: acc+x, wrapping modulo 2^DATA_W.
  - max: unsigned max(acc,x).
  - count: acc+1.
  - xor: acc^x.
  - len increments by 1.
  - If p==1, go to DONE; else p decrements by 1.
- DONE: res_valid=1 with res_data=acc, res_len=len and res_err held stable. On res_ready, go to IDLE, res_valid drops, and res_err clears.
- Cell writes arriving outside IDLE are back-pressured (cell_ready=0), never dropped.
- Simultaneous cell and head transfer in IDLE: the cell is committed in the same edge and is visible to the walk.

## Timing

- Reset values:
  - state=IDLE.
  - cell_ready=1, head_ready=1.
  - res_valid=0, res_data=0, res_len=0, res_err=0.
  - acc=0, len=0, p=0.
  - Memory contents are not reset.
- Head accepted at edge T with legal head_ptr=N>1: WALK occupies edges T+1..T+N-1, and res_valid rises after edge T+N-1. Fold latency is N-1 cycles after acceptance.
- N==1 or illegal head_ptr: res_valid rises after edge T+1.
- res_ready already high while res_valid is high: transfer occurs that edge, and cell_ready/head_ready are high the following cycle. No combinational path exists from res_ready to cell_ready or head_ready.
- rst asserted mid-WALK or mid-DONE: the fold is aborted, no result is emitted, and state returns to IDLE on that edge.
- Outputs are registered; res_data, res_len and res_err are stable while res_valid is high and not yet accepted.

## Structure

- Shared map_pkg holds:
  - element typedef (value, pointer pair), shared with map.
  - fold_op_e enum (FOLD_SUM, FOLD_MAX, FOLD_COUNT, FOLD_XOR).
  - fold_state_e enum.
  - NIL_IDX constant (0).
- Sub-module list_fold_mem: DEPTH x DATA_W register file, one synchronous write port, one combinational read port.
- The FSM and accumulator live in list_fold.

## Test plan

- Write cells 1..5 = 2,3,4,5,6 (Nil at 0), head_ptr=6, op=sum -> res_data=20, res_len=5, res_err=0; res_valid rises 5 cycles after the head transfer.
- Same cells, op=max then op=count then op=xor -> 6, 5, 2^3^4^5^6=6, each with res_len=5.
- head_ptr=1, op=sum -> res_data=0, res_len=0, res_valid one cycle after acceptance; head_ptr=0 and head_ptr=9 -> res_err=1, res_data=0.
- Cells 1..3 = 0xFFFFFFFF, head_ptr=4, op=sum -> res_data=0xFFFFFFFD (wrap); hold res_ready=0 for 3 cycles -> outputs stable, cell_ready=0, and a cell offer is accepted only after the result transfer.
- Assert rst during WALK of a 6-entry fold -> no res_valid; cell_ready and head_ready are high the next cycle; a new fold of cells 1..2 = 7,8 with op=sum -> 15.
